// File: rtl/bht_table_pkg.sv
// Shared definitions for the branch history table: geometry, the 2-bit
// saturating counter encodings and the controller state type.
package bht_table_pkg;

  localparam int BHTBTB_INDEX_WIDTH = 9;
  localparam int BHT_SETS           = 2 ** BHTBTB_INDEX_WIDTH;

  // Two-bit saturating counter encodings; the MSB is the taken prediction.
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  // Value every counter takes after an init sweep (weakly not taken).
  localparam logic [1:0] BHT_INIT_CNT = CNT_WNT;

  typedef enum logic {
    BHT_INIT,
    BHT_READY
  } bht_state_t;

endpackage

// File: rtl/bht_table_sat_counter2.sv
// Next-value logic for one 2-bit saturating branch counter.
// inc alone counts up toward strongly-taken, dec alone counts down toward
// strongly-not-taken; both or neither leave the counter unchanged.
module bht_sat_counter2
  import bht_table_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [1:0] cnt_o
);

  // Saturating step selected by the inc/dec pair.
  always_comb begin
    cnt_o = cnt_i;
    if (inc_i && !dec_i) begin
      case (cnt_i)
        CNT_SNT: cnt_o = CNT_WNT;
        CNT_WNT: cnt_o = CNT_WT;
        CNT_WT:  cnt_o = CNT_ST;
        default: cnt_o = CNT_ST;
      endcase
    end else if (dec_i && !inc_i) begin
      case (cnt_i)
        CNT_ST:  cnt_o = CNT_WT;
        CNT_WT:  cnt_o = CNT_WNT;
        CNT_WNT: cnt_o = CNT_SNT;
        default: cnt_o = CNT_SNT;
      endcase
    end
  end

endmodule

// File: rtl/bht_table.sv
// Branch history table: 512 sets of four 2-bit counters, one per 4-byte slot
// of a 16-byte fetch block. A registered read port serves the fetch predictor,
// a single-cycle read-modify-write port absorbs training from the branch unit,
// and an init sweep rewrites one set per cycle after reset or flush.
module bht_table
  import bht_table_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          bht_flush,
  input  logic                          bht_read_enable,
  input  logic [BHTBTB_INDEX_WIDTH-1:0] bht_read_index,
  output logic                          bht_read_ready,
  output logic                          bht_read_valid,
  output logic [7:0]                    bht_read_data,
  output logic                          bht_read_set_valid,
  output logic [3:0]                    bht_read_taken,
  input  logic                          bjusb_bht_write_enable,
  input  logic [BHTBTB_INDEX_WIDTH-1:0] bjusb_bht_write_index,
  input  logic [1:0]                    bjusb_bht_write_counter_select,
  input  logic                          bjusb_bht_write_inc,
  input  logic                          bjusb_bht_write_dec,
  input  logic                          bjusb_bht_valid_in,
  output logic                          bht_init_busy
);

  localparam logic [BHTBTB_INDEX_WIDTH:0] INIT_LAST = (BHTBTB_INDEX_WIDTH+1)'(BHT_SETS - 1);

  bht_state_t                    state_q, state_d;
  logic [BHTBTB_INDEX_WIDTH:0]   init_ptr_q, init_ptr_d;
  logic [BHTBTB_INDEX_WIDTH-1:0] init_idx;

  // Counter storage and per-set "trained since init" flags; no reset, the
  // sweep is the only initialisation.
  logic [7:0] cnt_mem  [BHT_SETS];
  logic       setv_mem [BHT_SETS];

  logic       rd_valid_q, rd_valid_d;
  logic [7:0] rd_data_q,  rd_data_d;
  logic       rd_setv_q,  rd_setv_d;

  logic       init_active;
  logic       rd_accept;
  logic       wr_effective;
  logic [7:0] wr_cur_word;
  logic [1:0] wr_cur_cnt;
  logic [1:0] wr_new_cnt;
  logic [7:0] wr_new_word;

  assign init_active = (state_q == BHT_INIT);
  assign init_idx    = init_ptr_q[BHTBTB_INDEX_WIDTH-1:0];
  assign rd_accept   = bht_read_enable && (state_q == BHT_READY);
  // A flush in the same cycle wins over training, so the write is dropped.
  assign wr_effective = bjusb_bht_write_enable && bjusb_bht_valid_in &&
                        (state_q == BHT_READY) && !bht_flush;

  // Controller next state: sweep one set per cycle, flush restarts the sweep.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    case (state_q)
      BHT_INIT: begin
        if (bht_flush) begin
          init_ptr_d = '0;
        end else if (init_ptr_q == INIT_LAST) begin
          state_d = BHT_READY;
        end else begin
          init_ptr_d = init_ptr_q + 1'b1;
        end
      end
      BHT_READY: begin
        if (bht_flush) begin
          state_d    = BHT_INIT;
          init_ptr_d = '0;
        end
      end
      default: begin
        state_d    = BHT_INIT;
        init_ptr_d = '0;
      end
    endcase
  end

  // Fetch the set being trained and isolate the selected counter.
  always_comb begin
    wr_cur_word = cnt_mem[bjusb_bht_write_index];
    wr_cur_cnt  = wr_cur_word[{bjusb_bht_write_counter_select, 1'b0} +: 2];
  end

  bht_sat_counter2 u_sat_counter (
    .cnt_i (wr_cur_cnt),
    .inc_i (bjusb_bht_write_inc),
    .dec_i (bjusb_bht_write_dec),
    .cnt_o (wr_new_cnt)
  );

  // Merge the updated counter back into its set.
  always_comb begin
    wr_new_word = wr_cur_word;
    wr_new_word[{bjusb_bht_write_counter_select, 1'b0} +: 2] = wr_new_cnt;
  end

  // Read response: write-first bypass on an index collision, else hold.
  always_comb begin
    rd_valid_d = rd_accept;
    rd_data_d  = rd_data_q;
    rd_setv_d  = rd_setv_q;
    if (rd_accept) begin
      if (wr_effective && (bjusb_bht_write_index == bht_read_index)) begin
        rd_data_d = wr_new_word;
        rd_setv_d = 1'b1;
      end else begin
        rd_data_d = cnt_mem[bht_read_index];
        rd_setv_d = setv_mem[bht_read_index];
      end
    end
  end

  // Controller and read-port registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BHT_INIT;
      init_ptr_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_setv_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_setv_q  <= rd_setv_d;
    end
  end

  // Array update: the sweep owns the arrays during INIT, training otherwise.
  always_ff @(posedge clock) begin
    if (init_active) begin
      cnt_mem[init_idx]  <= {4{BHT_INIT_CNT}};
      setv_mem[init_idx] <= 1'b0;
    end else if (wr_effective) begin
      cnt_mem[bjusb_bht_write_index]  <= wr_new_word;
      setv_mem[bjusb_bht_write_index] <= 1'b1;
    end
  end

  assign bht_read_ready     = (state_q == BHT_READY);
  assign bht_init_busy      = (state_q == BHT_INIT);
  assign bht_read_valid     = rd_valid_q;
  assign bht_read_data      = rd_data_q;
  assign bht_read_set_valid = rd_setv_q;
  assign bht_read_taken     = {rd_data_q[7], rd_data_q[5], rd_data_q[3], rd_data_q[1]};

endmodule

// File: tb/tb_bht_table.sv
// Self-checking bench for bht_table: a table of single-cycle vectors for
// training/read behaviour plus hand-written flush and reset sequences.
module tb_bht_table;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       bht_flush;
  logic       bht_read_enable;
  logic [8:0] bht_read_index;
  logic       bht_read_ready;
  logic       bht_read_valid;
  logic [7:0] bht_read_data;
  logic       bht_read_set_valid;
  logic [3:0] bht_read_taken;
  logic       bjusb_bht_write_enable;
  logic [8:0] bjusb_bht_write_index;
  logic [1:0] bjusb_bht_write_counter_select;
  logic       bjusb_bht_write_inc;
  logic       bjusb_bht_write_dec;
  logic       bjusb_bht_valid_in;
  logic       bht_init_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       we;
    logic [8:0] widx;
    logic [1:0] sel;
    logic       inc;
    logic       dec;
    logic       vin;
    logic       re;
    logic [8:0] ridx;
    logic       expValid;
    logic [7:0] expData;
    logic       expSetv;
    logic [3:0] expTaken;
  } vec_t;

  vec_t vecs [21];

  bht_table dut (
    .clock                          (clock),
    .reset_n                        (reset_n),
    .bht_flush                      (bht_flush),
    .bht_read_enable                (bht_read_enable),
    .bht_read_index                 (bht_read_index),
    .bht_read_ready                 (bht_read_ready),
    .bht_read_valid                 (bht_read_valid),
    .bht_read_data                  (bht_read_data),
    .bht_read_set_valid             (bht_read_set_valid),
    .bht_read_taken                 (bht_read_taken),
    .bjusb_bht_write_enable         (bjusb_bht_write_enable),
    .bjusb_bht_write_index          (bjusb_bht_write_index),
    .bjusb_bht_write_counter_select (bjusb_bht_write_counter_select),
    .bjusb_bht_write_inc            (bjusb_bht_write_inc),
    .bjusb_bht_write_dec            (bjusb_bht_write_dec),
    .bjusb_bht_valid_in             (bjusb_bht_valid_in),
    .bht_init_busy                  (bht_init_busy)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Watchdog so the run always ends even if a bounded loop is broken.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    bht_flush                      = 1'b0;
    bht_read_enable                = 1'b0;
    bht_read_index                 = '0;
    bjusb_bht_write_enable         = 1'b0;
    bjusb_bht_write_index          = '0;
    bjusb_bht_write_counter_select = '0;
    bjusb_bht_write_inc            = 1'b0;
    bjusb_bht_write_dec            = 1'b0;
    bjusb_bht_valid_in             = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bht_flush                      = 1'b0;
    bjusb_bht_write_enable         = v.we;
    bjusb_bht_write_index          = v.widx;
    bjusb_bht_write_counter_select = v.sel;
    bjusb_bht_write_inc            = v.inc;
    bjusb_bht_write_dec            = v.dec;
    bjusb_bht_valid_in             = v.vin;
    bht_read_enable                = v.re;
    bht_read_index                 = v.ridx;
  endtask

  task automatic driveWrite(input logic [8:0] idx, input logic [1:0] sel, input logic inc, input logic dec);
    bjusb_bht_write_enable         = 1'b1;
    bjusb_bht_write_index          = idx;
    bjusb_bht_write_counter_select = sel;
    bjusb_bht_write_inc            = inc;
    bjusb_bht_write_dec            = dec;
    bjusb_bht_valid_in             = 1'b1;
  endtask

  task automatic readAndCheck(input string tag, input logic [8:0] idx, input logic [7:0] expData,
                              input logic expSetv, input logic [3:0] expTaken);
    bht_read_enable = 1'b1;
    bht_read_index  = idx;
    tick();
    bht_read_enable = 1'b0;
    checkOutput({tag, ".valid"}, 16'(bht_read_valid), 16'd1);
    checkOutput({tag, ".data"}, 16'(bht_read_data), 16'(expData));
    checkOutput({tag, ".setValid"}, 16'(bht_read_set_valid), 16'(expSetv));
    checkOutput({tag, ".taken"}, 16'(bht_read_taken), 16'(expTaken));
  endtask

  // Counts busy cycles until READY (bounded), checking ready stays low and
  // that any reads held during the sweep are dropped.
  task automatic measureSweep(input string tag);
    int n;
    int sawReady;
    int sawValid;
    n = 0;
    sawReady = 0;
    sawValid = 0;
    while (bht_init_busy && n < 1000) begin
      if (bht_read_ready) sawReady++;
      n++;
      tick();
      if (bht_read_valid) sawValid++;
    end
    checkOutput({tag, ".busyCycles"}, 16'(n), 16'd512);
    checkOutput({tag, ".readyDuringInit"}, 16'(sawReady), 16'd0);
    checkOutput({tag, ".droppedReads"}, 16'(sawValid), 16'd0);
    checkOutput({tag, ".readyAfter"}, 16'(bht_read_ready), 16'd1);
  endtask

  initial begin
    //           we   widx    sel   inc   dec   vin   re    ridx    eV    eData  eS    eTaken
    vecs[0]  = '{1'b0, 9'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h1FF, 1'b1, 8'h55, 1'b0, 4'b0000};
    vecs[1]  = '{1'b1, 9'h023, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 8'h55, 1'b0, 4'b0000};
    vecs[2]  = '{1'b1, 9'h023, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 8'h55, 1'b0, 4'b0000};
    vecs[3]  = '{1'b1, 9'h023, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 8'h55, 1'b0, 4'b0000};
    vecs[4]  = '{1'b0, 9'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h023, 1'b1, 8'h75, 1'b1, 4'b0100};
    vecs[5]  = '{1'b1, 9'h023, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 8'h75, 1'b1, 4'b0100};
    vecs[6]  = '{1'b1, 9'h023, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 8'h75, 1'b1, 4'b0100};
    vecs[7]  = '{1'b1, 9'h023, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 8'h75, 1'b1, 4'b0100};
    vecs[8]  = '{1'b1, 9'h023, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 8'h75, 1'b1, 4'b0100};
    vecs[9]  = '{1'b1, 9'h023, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 8'h75, 1'b1, 4'b0100};
    vecs[10] = '{1'b0, 9'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h023, 1'b1, 8'h45, 1'b1, 4'b0000};
    vecs[11] = '{1'b1, 9'h010, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 8'h45, 1'b1, 4'b0000};
    vecs[12] = '{1'b0, 9'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h010, 1'b1, 8'h55, 1'b1, 4'b0000};
    vecs[13] = '{1'b1, 9'h011, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 8'h55, 1'b1, 4'b0000};
    vecs[14] = '{1'b0, 9'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h011, 1'b1, 8'h55, 1'b0, 4'b0000};
    vecs[15] = '{1'b1, 9'h0AB, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 9'h0AB, 1'b1, 8'h95, 1'b1, 4'b1000};
    vecs[16] = '{1'b1, 9'h0AB, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 9'h0AC, 1'b1, 8'h55, 1'b0, 4'b0000};
    vecs[17] = '{1'b0, 9'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h0AB, 1'b1, 8'hD5, 1'b1, 4'b1000};
    vecs[18] = '{1'b0, 9'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h023, 1'b1, 8'h45, 1'b1, 4'b0000};
    vecs[19] = '{1'b0, 9'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h010, 1'b1, 8'h55, 1'b1, 4'b0000};
    vecs[20] = '{1'b0, 9'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 8'h55, 1'b1, 4'b0000};

    clearInputs();
    reset_n = 1'b0;
    repeat (3) tick();
    $display("[TB] checking reset state");
    checkOutput("reset.busy", 16'(bht_init_busy), 16'd1);
    checkOutput("reset.ready", 16'(bht_read_ready), 16'd0);
    checkOutput("reset.valid", 16'(bht_read_valid), 16'd0);
    checkOutput("reset.data", 16'(bht_read_data), 16'd0);
    checkOutput("reset.setValid", 16'(bht_read_set_valid), 16'd0);
    checkOutput("reset.taken", 16'(bht_read_taken), 16'd0);

    reset_n = 1'b1;
    measureSweep("resetSweep");

    $display("[TB] applying vector table");
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("v%0d.valid", i), 16'(bht_read_valid), 16'(vecs[i].expValid));
      checkOutput($sformatf("v%0d.data", i), 16'(bht_read_data), 16'(vecs[i].expData));
      checkOutput($sformatf("v%0d.setValid", i), 16'(bht_read_set_valid), 16'(vecs[i].expSetv));
      checkOutput($sformatf("v%0d.taken", i), 16'(bht_read_taken), 16'(vecs[i].expTaken));
    end
    clearInputs();

    $display("[TB] flush sequence");
    for (int s = 0; s < 4; s++) begin
      repeat (2) begin
        driveWrite(9'h005, 2'(s), 1'b1, 1'b0);
        tick();
      end
    end
    clearInputs();
    readAndCheck("trained005", 9'h005, 8'hFF, 1'b1, 4'b1111);

    bht_flush = 1'b1;
    driveWrite(9'h005, 2'd0, 1'b0, 1'b1);
    bht_read_enable = 1'b1;
    bht_read_index  = 9'h005;
    tick();
    clearInputs();
    checkOutput("flushRead.valid", 16'(bht_read_valid), 16'd1);
    checkOutput("flushRead.data", 16'(bht_read_data), 16'hFF);
    checkOutput("flushRead.setValid", 16'(bht_read_set_valid), 16'd1);
    checkOutput("flush.busy", 16'(bht_init_busy), 16'd1);

    driveWrite(9'h005, 2'd1, 1'b0, 1'b1);
    bht_read_enable = 1'b1;
    bht_read_index  = 9'h005;
    measureSweep("flushSweep");
    clearInputs();
    readAndCheck("after flush 005", 9'h005, 8'h55, 1'b0, 4'b0000);

    $display("[TB] reset during sweep");
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int c = 1; c < 200; c++) begin
      bht_read_enable = (c == 100);
      tick();
      if (c == 100) checkOutput("midSweep.readAt100", 16'(bht_read_valid), 16'd0);
    end
    bht_read_enable = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("midReset.busy", 16'(bht_init_busy), 16'd1);
    checkOutput("midReset.ready", 16'(bht_read_ready), 16'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    measureSweep("midResetSweep");
    readAndCheck("after reset 0AB", 9'h0AB, 8'h55, 1'b0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
